// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: tracks in-flight destination tags to drive EX operand forwarding and ID stalls.
// Ports:
//   clk, reset           clock and asynchronous active-low reset
//   id_valid_i           instruction in ID is real
//   id_src_i             ID source tags, source j at [j*ADDR_W +: ADDR_W]
//   id_rd_i              ID destination tag
//   id_regwrite_i        ID instruction writes id_rd_i
//   id_memread_i         ID instruction is a load
//   flush_i              kill the instruction entering EX
//   fwd_en_i             1 = forwarding mode, 0 = full interlock
//   fwd_sel_o            per EX source: 0 = register file, k = producer stage M_k
//   stall_o              hold PC and IF/ID this cycle
//   stall_cnt_o          saturating count of stall cycles
module hazard_forward_unit #(
    parameter int ADDR_W    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_i,
    input  logic [ADDR_W-1:0]         id_rd_i,
    input  logic                      id_regwrite_i,
    input  logic                      id_memread_i,
    input  logic                      flush_i,
    input  logic                      fwd_en_i,
    output logic [NUM_SRC*2-1:0]      fwd_sel_o,
    output logic                      stall_o,
    output logic [15:0]               stall_cnt_o
);
    logic                      e_valid, e_rw, e_mr;
    logic [ADDR_W-1:0]         e_rd;
    logic [NUM_SRC*ADDR_W-1:0] e_src;
    logic                      m_valid [1:FWD_DEPTH];
    logic                      m_rw    [1:FWD_DEPTH];
    logic [ADDR_W-1:0]         m_rd    [1:FWD_DEPTH];
    logic                      hit;

    function automatic logic produces(input logic v, input logic rw,
                                      input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] r);
        return v && rw && rd == r && rd != '0;
    endfunction

    always_comb begin
        fwd_sel_o = '0;
        hit = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            // scan oldest to youngest so the nearest producer overwrites
            for (int k = FWD_DEPTH; k >= 1; k--)
                if (fwd_en_i && e_valid && produces(m_valid[k], m_rw[k], m_rd[k], e_src[j*ADDR_W +: ADDR_W]))
                    fwd_sel_o[j*2 +: 2] = 2'(k);
            if (produces(e_valid, e_rw, e_rd, id_src_i[j*ADDR_W +: ADDR_W]) && (e_mr || !fwd_en_i))
                hit = 1'b1;
            // interlock waits until the producer sits in the last stage, which the register file covers
            for (int k = 1; k < FWD_DEPTH; k++)
                if (!fwd_en_i && produces(m_valid[k], m_rw[k], m_rd[k], id_src_i[j*ADDR_W +: ADDR_W]))
                    hit = 1'b1;
        end
        stall_o = hit && id_valid_i && !flush_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid     <= 1'b0;
            e_rw        <= 1'b0;
            e_mr        <= 1'b0;
            e_rd        <= '0;
            e_src       <= '0;
            stall_cnt_o <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                m_valid[k] <= 1'b0;
                m_rw[k]    <= 1'b0;
                m_rd[k]    <= '0;
            end
        end else begin
            m_valid[1] <= e_valid;
            m_rw[1]    <= e_rw;
            m_rd[1]    <= e_rd;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                m_valid[k] <= m_valid[k-1];
                m_rw[k]    <= m_rw[k-1];
                m_rd[k]    <= m_rd[k-1];
            end
            e_valid <= id_valid_i && !stall_o && !flush_i;
            if (!stall_o && !flush_i) begin
                e_rw  <= id_regwrite_i;
                e_mr  <= id_memread_i;
                e_rd  <= id_rd_i;
                e_src <= id_src_i;
            end
            if (stall_o && stall_cnt_o != 16'hFFFF)
                stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
endmodule
